// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Writeback arbiter that sits in front of the register file's single write
// port. It merges two result streams onto that port:
//   - ALU results. These have priority and cannot be back-pressured.
//   - Load results. These are buffered in a small FIFO and drained during
//     slots the ALU does not use.
// Writes to x0 are discarded. Write-after-write order is preserved by
// squashing any buffered load that a newer ALU write to the same register
// overtakes.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   alu_valid    ALU result valid this cycle
//   alu_addr     ALU destination register
//   alu_data     ALU result
//   alu_stall    registered; upstream must hold alu_valid=0 while it is high
//   ld_valid     load result offered
//   ld_ready     load accepted when ld_valid && ld_ready (combinational !full)
//   ld_addr      load destination register
//   ld_data      load data
//   rg_wrt_en    register file write enable (one-cycle pulse per write)
//   rg_wrt_addr  register file write address
//   rg_wrt_data  register file write data
//   fifo_count   entries held in the load FIFO, live or squashed
module rf_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_addr,
  input  logic [31:0]              alu_data,
  output logic                     alu_stall,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     rg_wrt_en,
  output logic [4:0]               rg_wrt_addr,
  output logic [31:0]              rg_wrt_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  // Load FIFO storage. The payload needs no reset: it is only read while
  // r_count says the slot is occupied.
  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;
  logic             r_stall;

  logic             r_wen;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;

  logic             w_empty;
  logic             w_full;
  logic             w_alu_win;
  logic             w_head_vld;
  logic             w_head_wr;
  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_count_nxt;
  logic [SW-1:0]    w_starve_nxt;
  logic [DEPTH-1:0] w_vld_nxt;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_alu_win = alu_valid && (alu_addr != 5'd0);

  // The head is only meaningful while the FIFO is non-empty.
  assign w_head_vld = !w_empty && r_vld[r_rd_ptr] && (r_addr[r_rd_ptr] != 5'd0);
  assign w_head_wr  = !w_alu_win && w_head_vld;

  // Any slot the ALU leaves free consumes the head. A squashed head pops
  // without a write.
  assign w_pop = !w_alu_win && !w_empty;

  // A load to x0 completes its handshake but is dropped. So is a load that
  // collides with a same-cycle ALU write to the same register: the load is
  // older, so the ALU value must be the one left in the register file.
  assign w_push = ld_valid && !w_full && (ld_addr != 5'd0) &&
                  !(w_alu_win && (ld_addr == alu_addr));

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Starvation counter. It counts ALU wins while loads are waiting, clears
  // on any pop or when the FIFO is empty, and saturates at the limit. The
  // saturation also covers an ALU write that arrives while stalled.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (w_alu_win && (r_starve != LIMIT_C)) begin
      w_starve_nxt = r_starve + 1'b1;
    end
  end

  // WAW squash. A newer ALU write to a register invalidates every buffered
  // load to that register. Unoccupied slots may be cleared as well; that is
  // harmless because a push sets the valid bit again.
  always_comb begin
    w_vld_nxt = r_vld;
    if (w_alu_win) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_addr[i] == alu_addr) begin
          w_vld_nxt[i] = 1'b0;
        end
      end
    end
    if (w_push) begin
      w_vld_nxt[r_wr_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= ld_addr;
      r_data[r_wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
      r_wen    <= 1'b0;
      r_waddr  <= 5'd0;
      r_wdata  <= 32'd0;
    end else begin
      r_vld    <= w_vld_nxt;
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      // Raised in the same edge the counter reaches the limit. It falls one
      // cycle after the pop that clears the counter.
      r_stall  <= (w_starve_nxt == LIMIT_C);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Write port: the ALU wins first, then a live head. Otherwise the port
      // stays idle and address/data hold their last values.
      r_wen <= w_alu_win || w_head_wr;
      if (w_alu_win) begin
        r_waddr <= alu_addr;
        r_wdata <= alu_data;
      end else if (w_head_wr) begin
        r_waddr <= r_addr[r_rd_ptr];
        r_wdata <= r_data[r_rd_ptr];
      end
    end
  end

  assign ld_ready    = !w_full;
  assign alu_stall   = r_stall;
  assign rg_wrt_en   = r_wen;
  assign rg_wrt_addr = r_waddr;
  assign rg_wrt_data = r_wdata;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter. Expected register-file writes are
// queued as {addr,data} when stimulus is driven. Every write pulse the DUT
// produces is popped from that queue and compared.
module tb_rf_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_addr;
  logic [31:0] rg_wrt_data;
  logic [$clog2(DEPTH):0] fifo_count;

  logic [36:0] exp_q[$];
  int total;
  int bad;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .rg_wrt_en  (rg_wrt_en),
    .rg_wrt_addr(rg_wrt_addr),
    .rg_wrt_data(rg_wrt_data),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Advance one clock. Outputs are sampled 1 time unit after the edge, and
  // any write pulse is checked against the head of the scoreboard.
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (rg_wrt_en !== 1'b0) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%0d:%h expected=none", rg_wrt_addr, rg_wrt_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert ({rg_wrt_en, rg_wrt_addr, rg_wrt_data} === {1'b1, e}) else begin
          bad++;
          $error("FAIL write observed=%0d:%h expected=%0d:%h",
                 rg_wrt_addr, rg_wrt_data, e[36:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
    ld_valid  = 1'b0; ld_addr  = 5'd0; ld_data  = 32'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen",   32'(rg_wrt_en),   32'd0);
    chk("rst_waddr", 32'(rg_wrt_addr), 32'd0);
    chk("rst_wdata", rg_wrt_data,      32'd0);
    chk("rst_count", 32'(fifo_count),  32'd0);
    chk("rst_stall", 32'(alu_stall),   32'd0);
    chk("rst_ready", 32'(ld_ready),    32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write, 1-cycle latency
    alu_valid = 1'b1; alu_addr = 5'd18; alu_data = 32'h0035_6423;
    expect_wr(5'd18, 32'h0035_6423);
    tick();
    idle_inputs();
    chk("alu_wen", 32'(rg_wrt_en), 32'd1);
    tick();
    chk("alu_wen_drop", 32'(rg_wrt_en), 32'd0);

    // Single load through the FIFO
    chk("ld_ready_idle", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    chk("ld_count1", 32'(fifo_count), 32'd1);
    chk("ld_wen_lat1", 32'(rg_wrt_en), 32'd0);
    tick();
    chk("ld_wen_lat2", 32'(rg_wrt_en), 32'd1);
    chk("ld_count0", 32'(fifo_count), 32'd0);
    chk("ld_q_empty", 32'(exp_q.size()), 32'd0);

    // ALU every cycle, four loads fill the FIFO, then starvation stall
    for (int i = 0; i < 9; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(20 + i); alu_data = 32'hA000_0000 + 32'(i);
      expect_wr(5'(20 + i), 32'hA000_0000 + 32'(i));
      ld_valid = (i < 4);
      ld_addr  = 5'(i + 1);
      ld_data  = 32'h100 + 32'(i);
      tick();
      chk($sformatf("starve_stall_%0d", i), 32'(alu_stall), (i == 8) ? 32'd1 : 32'd0);
    end
    idle_inputs();
    chk("full_ready", 32'(ld_ready),   32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) expect_wr(5'(i + 1), 32'h100 + 32'(i));
    tick();
    chk("drain_stall_off", 32'(alu_stall),  32'd0);
    chk("drain_count3",    32'(fifo_count), 32'd3);
    chk("drain_ready",     32'(ld_ready),   32'd1);
    repeat (3) tick();
    chk("drain_count0", 32'(fifo_count), 32'd0);
    chk("drain_q_empty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("drain_idle", 32'(rg_wrt_en), 32'd0);

    // WAW: a buffered load is squashed by a newer ALU write
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h11;
    tick();
    idle_inputs();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h22;
    expect_wr(5'd7, 32'h22);
    tick();
    idle_inputs();
    tick();
    chk("squash_nowrite", 32'(rg_wrt_en),  32'd0);
    chk("squash_count0",  32'(fifo_count), 32'd0);

    // WAW: same-cycle ALU and load to one register, the load is dropped
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'hAAAA;
    ld_valid  = 1'b1; ld_addr  = 5'd9; ld_data  = 32'hBBBB;
    chk("same_ready", 32'(ld_ready), 32'd1);
    expect_wr(5'd9, 32'hAAAA);
    tick();
    idle_inputs();
    chk("same_count0", 32'(fifo_count), 32'd0);
    tick();
    chk("same_idle", 32'(rg_wrt_en), 32'd0);
    chk("waw_q_empty", 32'(exp_q.size()), 32'd0);

    // Writes to x0 from both sources are discarded
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h5555;
    ld_valid  = 1'b1; ld_addr  = 5'd0; ld_data  = 32'h6666;
    chk("x0_ready", 32'(ld_ready), 32'd1);
    tick();
    idle_inputs();
    chk("x0_wen1",   32'(rg_wrt_en),  32'd0);
    chk("x0_count0", 32'(fifo_count), 32'd0);
    tick();
    chk("x0_wen2", 32'(rg_wrt_en), 32'd0);

    // Reset in the middle of operation with three loads buffered
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(25 + i); alu_data = 32'hC0 + 32'(i);
      expect_wr(5'(25 + i), 32'hC0 + 32'(i));
      ld_valid = 1'b1; ld_addr = 5'(11 + i); ld_data = 32'(i);
      tick();
    end
    idle_inputs();
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_wen",   32'(rg_wrt_en),  32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen",   32'(rg_wrt_en),   32'd0);
    chk("mid_rst_waddr", 32'(rg_wrt_addr), 32'd0);
    chk("mid_rst_wdata", rg_wrt_data,      32'd0);
    chk("mid_rst_count", 32'(fifo_count),  32'd0);
    chk("mid_rst_stall", 32'(alu_stall),   32'd0);
    chk("mid_rst_ready", 32'(ld_ready),    32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    chk("post_rst_wen",   32'(rg_wrt_en),  32'd0);
    chk("final_q_empty",  32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
